// File: rtl/fp_convert_stream.sv
// rtl/fp_convert_stream.sv - multi-channel fixed-point format converter, 2-stage streaming pipeline
// Stage 1 aligns/rounds each channel; stage 2 range-checks, saturates or wraps, and flags clips.
module fp_convert_stream #(
  parameter int N_CH       = 4,
  parameter int IN_IW      = 4,
  parameter int IN_QW      = 12,
  parameter int OUT_IW     = 2,
  parameter int OUT_QW     = 8,
  parameter int IN_SIGNED  = 1,
  parameter int OUT_SIGNED = 1,
  parameter int CLIP       = 1,
  parameter int RND        = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N_CH*(IN_IW+IN_QW)-1:0]       in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [N_CH*(OUT_IW+OUT_QW)-1:0]     out_data,
  output logic [N_CH-1:0]                     out_clip,
  input  logic                                cnt_clr,
  output logic [CNT_W-1:0]                    clip_cnt
);

  localparam int WI = IN_IW + IN_QW;
  localparam int WO = OUT_IW + OUT_QW;
  localparam int SH = (OUT_QW >= IN_QW) ? OUT_QW - IN_QW : 0;
  localparam int K  = (OUT_QW < IN_QW) ? IN_QW - OUT_QW : 0;
  // One extra bit makes unsigned inputs non-negative in a signed container.
  localparam int EW = WI + 1;
  // Aligned width plus one guard bit so a rounding carry cannot wrap.
  localparam int AW = EW - K + SH + 1;
  localparam int CW = ((AW > WO + 2) ? AW : WO + 2) + 1;
  localparam logic signed [CW-1:0] ONE = 1;
  localparam logic signed [CW-1:0] HI  = (OUT_SIGNED != 0) ? (ONE <<< (WO - 1)) - ONE
                                                            : (ONE <<< WO) - ONE;
  localparam logic signed [CW-1:0] LO  = (OUT_SIGNED != 0) ? -(ONE <<< (WO - 1)) : '0;

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("fp_convert_stream: N_CH must be in 1..16");
  end
  if (RND < 0 || RND > 2) begin : g_bad_rnd
    $error("fp_convert_stream: RND must be 0, 1 or 2");
  end
  if (WI < 2 || WI > 63 || WO < 2 || WO > 63) begin : g_bad_wl
    $error("fp_convert_stream: word lengths must be in 2..63");
  end

  logic [N_CH*AW-1:0] rnd_all;
  logic [N_CH*AW-1:0] s1_data;
  logic [N_CH*WO-1:0] sat_all;
  logic [N_CH-1:0]    flag_all;
  logic               s1_valid;
  logic               s1_load;
  logic               s2_load;

  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [WI-1:0]         din;
    logic signed [EW-1:0]  ext;
    logic signed [AW-1:0]  rnd;
    logic signed [AW-1:0]  s;
    logic signed [CW-1:0]  v;
    logic                  over;
    logic                  under;

    assign din = in_data[c*WI +: WI];
    assign ext = (IN_SIGNED != 0) ? {din[WI-1], din} : {1'b0, din};

    if (OUT_QW >= IN_QW) begin : g_shl
      assign rnd = {{(SH+1){ext[EW-1]}}, ext} << SH;
    end else begin : g_round
      logic signed [EW-K-1:0] flr;
      logic                   rbit;
      logic                   sticky;
      logic                   inc;
      logic                   unused_rnd_bits;

      assign flr  = ext[EW-1:K];
      assign rbit = ext[K-1];
      if (K > 1) begin : g_sticky
        assign sticky = |ext[K-2:0];
      end else begin : g_nosticky
        assign sticky = 1'b0;
      end
      // Convergent mode only bumps a tie when the floored value is odd.
      assign inc = (RND == 0) ? 1'b0
                 : (RND == 1) ? rbit
                 : (rbit && (sticky || flr[0]));
      assign rnd = {flr[EW-K-1], flr} + {{(AW-1){1'b0}}, inc};
      assign unused_rnd_bits = rbit ^ sticky;
    end

    assign rnd_all[c*AW +: AW] = rnd;

    assign s     = s1_data[c*AW +: AW];
    assign v     = {{(CW-AW){s[AW-1]}}, s};
    assign over  = v > HI;
    assign under = v < LO;

    assign flag_all[c]         = over || under;
    assign sat_all[c*WO +: WO] = (CLIP != 0 && over)  ? HI[WO-1:0]
                               : (CLIP != 0 && under) ? LO[WO-1:0]
                               : v[WO-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= rnd_all;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_clip  <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out_data  <= sat_all;
        out_clip  <= flag_all;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt <= '0;
    end else if (cnt_clr) begin
      clip_cnt <= '0;
    end else if (out_valid && out_ready && (|out_clip) && (clip_cnt != {CNT_W{1'b1}})) begin
      clip_cnt <= clip_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_convert_stream.sv
// tb/tb_fp_convert_stream.sv - self-checking bench for fp_convert_stream
// Four DUTs differ in RND/CLIP; a fifth uses a 4-bit clip counter.
module tb_fp_convert_stream;

  localparam int NV = 11;

  typedef struct {
    logic [15:0] din;
    logic [9:0]  e1;
    logic        c1;
    logic [9:0]  e0;
    logic        c0;
    logic [9:0]  e2;
    logic [9:0]  ew;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [63:0] in_data;
  logic        ir [5];
  logic        ov [5];
  logic [39:0] od [5];
  logic [3:0]  oc [5];
  logic [15:0] cnt_a [4];
  logic [3:0]  cnt_c;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_acc     = 0;
  int n_del     = 0;
  int exp16     = 0;
  int exp4      = 0;
  logic [63:0] q [$];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    fp_convert_stream #(
      .RND  ((i == 1) ? 0 : ((i == 2) ? 2 : 1)),
      .CLIP ((i == 3) ? 0 : 1)
    ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[i]), .in_data(in_data),
      .out_valid(ov[i]), .out_ready(out_ready), .out_data(od[i]), .out_clip(oc[i]),
      .cnt_clr(cnt_clr), .clip_cnt(cnt_a[i])
    );
  end

  fp_convert_stream #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]), .in_data(in_data),
    .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .out_clip(oc[4]),
    .cnt_clr(cnt_clr), .clip_cnt(cnt_c)
  );

  function automatic int cfg_rnd(input int d);
    return (d == 1) ? 0 : ((d == 2) ? 2 : 1);
  endfunction

  function automatic bit cfg_clip(input int d);
    return (d == 3) ? 1'b0 : 1'b1;
  endfunction

  // Reference: value in output LSB units as a real, rounded, then range-limited.
  function automatic void model(input logic [15:0] x, input int rnd, input bit clip,
                                output logic [9:0] y, output logic f);
    real r, fl;
    int  v, fi;
    r  = $itor($signed(x)) / 16.0;
    fl = $floor(r);
    fi = $rtoi(fl);
    if (rnd == 0) v = fi;
    else if (rnd == 1) v = $rtoi($floor(r + 0.5));
    else if (r - fl == 0.5) v = (fi % 2 == 0) ? fi : fi + 1;
    else v = $rtoi($floor(r + 0.5));
    f = (v > 511) || (v < -512);
    if (clip && v > 511) v = 511;
    else if (clip && v < -512) v = -512;
    y = v[9:0];
  endfunction

  function automatic void model_beat(input logic [63:0] x, input int d,
                                     output logic [39:0] y, output logic [3:0] f);
    logic [9:0] yc;
    logic       fc;
    for (int c = 0; c < 4; c++) begin
      model(x[c*16 +: 16], cfg_rnd(d), cfg_clip(d), yc, fc);
      y[c*10 +: 10] = yc;
      f[c]          = fc;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin : monitor
    logic [39:0] ey;
    logic [3:0]  ef;
    logic        any;
    if (!rst_n) begin
      q.delete();
      exp16 = 0;
      exp4  = 0;
    end else begin
      any = 1'b0;
      if (ov[0]) begin
        if (q.size() == 0) begin
          total_cnt++;
          $display("FAIL spurious_beat: out_valid=1 with no beat pending");
        end else begin
          for (int d = 0; d < 5; d++) begin
            model_beat(q[0], d, ey, ef);
            check($sformatf("beat_dut%0d", d), {19'd0, ov[d], oc[d], od[d]}, {19'd0, 1'b1, ef, ey});
            if (d == 0) any = |ef;
          end
          if (out_ready) begin
            void'(q.pop_front());
            n_del++;
          end
        end
      end
      if (cnt_clr) begin
        exp16 = 0;
        exp4  = 0;
      end else if (ov[0] && out_ready && any) begin
        if (exp16 < 65535) exp16++;
        if (exp4 < 15) exp4++;
      end
      if (in_valid && ir[0]) begin
        q.push_back(in_data);
        n_acc++;
      end
    end
  end

  initial begin
    vec_t        tab [NV];
    vec_t        t;
    logic [39:0] ev [4];
    logic [3:0]  ef [4];
    logic [15:0] w;
    int          lat, nr, nov, k, d0, cyc;
    bit          acc, saw_low;

    tab[0]  = '{16'h0018, 10'h002, 1'b0, 10'h001, 1'b0, 10'h002, 10'h002};
    tab[1]  = '{16'h0028, 10'h003, 1'b0, 10'h002, 1'b0, 10'h002, 10'h003};
    tab[2]  = '{16'h3000, 10'h1FF, 1'b1, 10'h1FF, 1'b1, 10'h1FF, 10'h300};
    tab[3]  = '{16'h8000, 10'h200, 1'b1, 10'h200, 1'b1, 10'h200, 10'h000};
    tab[4]  = '{16'h1FFF, 10'h1FF, 1'b1, 10'h1FF, 1'b0, 10'h1FF, 10'h200};
    tab[5]  = '{16'h0000, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 10'h000};
    tab[6]  = '{16'hFFF8, 10'h000, 1'b0, 10'h3FF, 1'b0, 10'h000, 10'h000};
    tab[7]  = '{16'h7FFF, 10'h1FF, 1'b1, 10'h1FF, 1'b1, 10'h1FF, 10'h000};
    tab[8]  = '{16'hF000, 10'h300, 1'b0, 10'h300, 1'b0, 10'h300, 10'h300};
    tab[9]  = '{16'h2008, 10'h1FF, 1'b1, 10'h1FF, 1'b1, 10'h1FF, 10'h201};
    tab[10] = '{16'hDFF8, 10'h200, 1'b0, 10'h200, 1'b1, 10'h200, 10'h200};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", ov[0], 0);
    check("reset_out_data", od[0], 0);
    check("reset_out_clip", oc[0], 0);
    check("reset_clip_cnt", cnt_a[0], 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", ir[0], 1);

    // Directed table, rotated across channels so every lane sees every vector.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = tab[(i + c) % NV].din;
      in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ov[0] && lat < 10);
      if (i == 0) check("latency", lat, 2);
      for (int c = 0; c < 4; c++) begin
        t = tab[(i + c) % NV];
        ev[0][c*10 +: 10] = t.e1; ef[0][c] = t.c1;
        ev[1][c*10 +: 10] = t.e0; ef[1][c] = t.c0;
        ev[2][c*10 +: 10] = t.e2; ef[2][c] = t.c1;
        ev[3][c*10 +: 10] = t.ew; ef[3][c] = t.c1;
      end
      for (int d = 0; d < 4; d++)
        check($sformatf("table%0d_dut%0d", i, d), {20'd0, oc[d], od[d]}, {20'd0, ef[d], ev[d]});
    end
    @(negedge clk);
    check("cnt_model_after_table", cnt_a[0], 64'(exp16));

    // Sustained throughput: 8 back-to-back beats.
    @(posedge clk); #1; in_valid = 1'b1; nr = 0; nov = 0;
    for (int b = 0; b < 8; b++) begin
      in_data = {$urandom, $urandom};
      @(negedge clk);
      if (ir[0]) nr++;
      if (ov[0]) nov++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin @(negedge clk); if (ov[0]) nov++; end
    check("tput_in_ready", nr, 8);
    check("tput_out_beats", nov, 8);

    // Backpressure: 10 beats, out_ready low in cycles 3..7.
    @(posedge clk); #1;
    k = 0; saw_low = 1'b0; d0 = n_del;
    for (int c2 = 0; c2 < 60 && (n_del - d0) < 10; c2++) begin
      out_ready = !(c2 >= 3 && c2 <= 7);
      in_valid  = (k < 10);
      in_data   = {16'(16'h0100 + k), 16'(16'hE000 - k), 16'(16'h2000 + 3 * k), 16'(k)};
      @(negedge clk);
      acc = in_valid && ir[0];
      if (in_valid && !ir[0]) saw_low = 1'b1;
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_in_ready_low", saw_low, 1);
    check("bp_delivered", n_del - d0, 10);

    // Counter saturation on the 4-bit instance.
    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = {4{16'h3000}};
    repeat (20) @(posedge clk);
    #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("cnt4_saturated", cnt_c, 15);
    check("cnt16_count", cnt_a[0], 20);

    // Clear coinciding with a clipping delivery.
    out_ready = 1'b0; in_valid = 1'b1; in_data = {4{16'h8000}};
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ov[0] && lat < 10);
    if (!ov[0]) fail_now("clr_wait_valid");
    @(posedge clk); #1; cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr_wins16", cnt_a[0], 0);
    check("cnt_clr_wins4", cnt_c, 0);

    // Randomized traffic with random backpressure.
    d0 = n_acc; cyc = 0;
    while ((n_acc - d0) < 400 && cyc < 6000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 1) == 1) w = {{5{w[10]}}, w[10:0]};
        in_data[c*16 +: 16] = w;
      end
      cyc++;
    end
    if ((n_acc - d0) < 400) fail_now("rand_accept_budget");
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rand_drained", q.size(), 0);
    check("rand_cnt16_model", cnt_a[0], 64'(exp16));
    check("rand_cnt4_model", cnt_c, 64'(exp4));

    // Reset with both stages occupied.
    @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_data = {4{16'(16'h1234 + b)}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_out_valid", ov[0], 1);
    @(posedge clk); #1; rst_n = 1'b0; #1;
    check("rst_async_out_valid", ov[0], 0);
    check("rst_async_out_data", od[0], 0);
    check("rst_async_out_clip", oc[0], 0);
    check("rst_async_clip_cnt", cnt_c, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("rst_in_ready", ir[0], 1);
    nov = 0;
    repeat (6) begin @(negedge clk); if (ov[0]) nov++; end
    check("rst_no_stale_beat", nov, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_convert_stream.md
FP_CONVERT_STREAM -- requirements
Module: fp_convert_stream

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of parallel channels, range 1..16.
REQ-002 SHALL have parameter IN_IW, default 4: input integer bits, including the sign bit when IN_SIGNED=1.
REQ-003 SHALL have parameter IN_QW, default 12: input fractional bits.
REQ-004 SHALL have parameter OUT_IW, default 2: output integer bits, including the sign bit when OUT_SIGNED=1.
REQ-005 SHALL have parameter OUT_QW, default 8: output fractional bits.
REQ-006 SHALL have parameter IN_SIGNED, default 1: 1 = two's complement input, 0 = unsigned input.
REQ-007 SHALL have parameter OUT_SIGNED, default 1: 1 = two's complement output, 0 = unsigned output.
REQ-008 SHALL have parameter CLIP, default 1: 1 = saturate, 0 = wrap.
REQ-009 SHALL have parameter RND, default 1: 0 = floor, 1 = round-half-up, 2 = convergent.
REQ-010 SHALL have parameter CNT_W, default 16: clip counter width.
REQ-011 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-012 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-013 SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-014 SHALL have port in_ready, output, 1 bit: input beat accepted when in_valid and in_ready are both high.
REQ-015 SHALL have port in_data, input, N_CH*(IN_IW+IN_QW) bits: channel c occupies slice c, with channel 0 at the LSBs.
REQ-016 SHALL have port out_valid, output, 1 bit: output beat valid.
REQ-017 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-018 SHALL have port out_data, output, N_CH*(OUT_IW+OUT_QW) bits: converted channels, same packing as in_data.
REQ-019 SHALL have port out_clip, output, N_CH bits: per-channel out-of-range flag, aligned with out_data.
REQ-020 SHALL have port cnt_clr, input, 1 bit: synchronous clear of clip_cnt.
REQ-021 SHALL have port clip_cnt, output, CNT_W bits: saturating count of delivered beats that had any flag set.

Function
REQ-022 SHALL raise $error at elaboration in these cases: N_CH outside 1..16, RND outside 0..2, or either word length outside 2..63.
REQ-023 SHALL extend each input to a common internal width: sign-extended if IN_SIGNED=1, zero-extended if IN_SIGNED=0.
REQ-024 SHALL left-shift the input by OUT_QW-IN_QW, exactly and with no rounding, when OUT_QW>=IN_QW.
REQ-025 SHALL drop k=IN_QW-OUT_QW LSBs when OUT_QW<IN_QW, with rounding as follows:
- RND=0: floor.
- RND=1: add 2^(k-1), then floor.
- RND=2: as RND=1, except an exact tie rounds to an even result.
REQ-026 SHALL compute the rounded value with one guard integer bit, so a rounding carry cannot wrap before the range check.
REQ-027 SHALL range-check each channel against the output range:
- OUT_SIGNED=1: [-2^(WL-1), 2^(WL-1)-1], where WL=OUT_IW+OUT_QW.
- OUT_SIGNED=0: [0, 2^WL-1].
REQ-028 SHALL, when a channel is out of range and CLIP=1, output the nearest range limit; when CLIP=0, output the WL LSBs (wrap).
REQ-029 SHALL set out_clip[c] whenever channel c was out of range, in either CLIP mode.
REQ-030 SHALL be a 2-stage pipeline: stage 1 aligns and rounds, stage 2 range-checks, saturates and registers the outputs.
REQ-031 SHALL present an accepted beat on out_valid 2 cycles after acceptance when out_ready is held high.
REQ-032 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-033 SHALL drive in_ready = !s1_valid || !out_valid || out_ready; a combinational ready path is permitted.
REQ-034 SHALL, while out_valid=1 and out_ready=0, hold out_data and out_clip stable, with no beat lost or duplicated.
REQ-035 SHALL, in the same cycle as a downstream stall, still accept a beat into an empty stage 1.
REQ-036 SHALL increment clip_cnt by 1 on each beat with out_valid && out_ready && |out_clip.
REQ-037 SHALL hold clip_cnt at 2^CNT_W-1 once it reaches that value (saturating).
REQ-038 SHALL clear clip_cnt to 0 next cycle when cnt_clr=1; clear wins over a same-cycle increment.
REQ-039 SHALL process all channels in lockstep, sharing one valid/ready pair.

Reset
REQ-040 SHALL, while rst_n=0, drive immediately (asynchronously): out_valid=0, out_data=0, out_clip=0, clip_cnt=0, and both stage valids=0.
REQ-041 SHALL drive in_ready=1 from the first cycle after rst_n deasserts.
REQ-042 SHALL discard all in-flight beats on a reset mid-operation and not output them afterwards.

Verification (defaults unless stated: in 4.12 signed, out 2.8 signed)
REQ-043 SHALL cover rounding:
- in 0x0018 -> out 0x002 for RND=1 and RND=2, 0x001 for RND=0.
- in 0x0028 -> out 0x003 for RND=1, 0x002 for RND=2 and RND=0.
- out_clip=0 in all cases.
REQ-044 SHALL cover saturation and wrap:
- CLIP=1: in 0x3000 (+3.0) -> 0x1FF with clip=1; in 0x8000 (-8.0) -> 0x200 with clip=1.
- CLIP=0: in 0x3000 -> 0x300 with clip=1.
REQ-045 SHALL cover rounding carry: in 0x1FFF with RND=1 -> 0x1FF, clip=1.
REQ-046 SHALL cover backpressure: 10-beat stream with out_ready low for cycles 3-7 -> in_ready low once both stages are full, and all 10 beats delivered in order and unchanged.
REQ-047 SHALL cover the counter: CNT_W=4, 20 clipping beats -> clip_cnt=15; cnt_clr asserted together with a clipping beat -> clip_cnt=0.
REQ-048 SHALL cover reset mid-stream: rst_n pulsed low with 2 beats in flight -> outputs zero immediately, and no stale beat appears after release.
